// File: rtl/latch.sv
// Gated D latch built on an edge-triggered register, so no level-sensitive cell is inferred.
// Latency is 0 cycles when transparent with st=1, otherwise 1 cycle. There is no backpressure; st only gates capture.
module latch #(
  parameter int unsigned WIDTH       = 1,
  parameter bit          TRANSPARENT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (st) begin
      q <= d;
    end
  end

  // The bypass only affects o. q stays cleared while rst is high, even when st=1.
  generate
    if (TRANSPARENT) begin : g_transparent
      assign o = st ? d : q;
    end else begin : g_registered
      assign o = q;
    end
  endgenerate

endmodule

// File: tb/tb_latch.sv
// Directed bench for latch: transparent 1-bit instance and registered 8-bit instance.
module tb_latch;

  logic       clk;
  logic       rst_t, st_t;
  logic [0:0] d_t, o_t;
  logic       rst_r, st_r;
  logic [7:0] d_r, o_r;

  int passed;
  int total;

  latch #(.WIDTH(1), .TRANSPARENT(1'b1)) u_t (
    .clk(clk), .rst(rst_t), .st(st_t), .d(d_t), .o(o_t)
  );

  latch #(.WIDTH(8), .TRANSPARENT(1'b0)) u_r (
    .clk(clk), .rst(rst_r), .st(st_r), .d(d_r), .o(o_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks for the 1-bit transparent instance and the 8-bit registered instance.
  task automatic chk_t(input string name, input logic exp);
    total++;
    if (o_t !== exp) $display("FAIL %s: o=%b expected %b", name, o_t, exp);
    else passed++;
  endtask

  task automatic chk_r(input string name, input logic [7:0] exp);
    total++;
    if (o_r !== exp) $display("FAIL %s: o=%h expected %h", name, o_r, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_t = 1'b1; st_t = 1'b0; d_t = 1'b1;
    rst_r = 1'b1; st_r = 1'b1; d_r = 8'hFF;
    tick();
    chk_t("reset_t", 1'b0);
    chk_r("reset_r", 8'h00);
    rst_t = 1'b0; rst_r = 1'b0; st_r = 1'b0;
    tick();
    chk_t("reset_t_after_release", 1'b0);
    chk_r("reset_r_after_release", 8'h00);
  endtask

  task automatic test_transparent_follow();
    logic [3:0] pat;
    pat = 4'b1010;
    st_t = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_t = pat[i];
      #1;
      chk_t($sformatf("follow_comb_%0d", i), pat[i]);
      tick();
      chk_t($sformatf("follow_clk_%0d", i), pat[i]);
    end
  endtask

  task automatic test_hold_capture();
    logic [2:0] dv;
    dv = 3'b101;
    st_t = 1'b1; d_t = 1'b1;
    tick();
    st_t = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_t = dv[i];
      #1;
      chk_t($sformatf("hold1_comb_%0d", i), 1'b1);
      tick();
      tick();
      chk_t($sformatf("hold1_clk_%0d", i), 1'b1);
    end
  endtask

  task automatic test_hold_zero();
    st_t = 1'b1; d_t = 1'b0;
    tick();
    st_t = 1'b0; d_t = 1'b1;
    #1;
    chk_t("hold0_comb", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_t($sformatf("hold0_clk_%0d", i), 1'b0);
    end
  endtask

  task automatic test_async_reset();
    st_t = 1'b1; d_t = 1'b1;
    tick();
    st_t = 1'b0;
    #1;
    chk_t("areset_pre", 1'b1);
    #1 rst_t = 1'b1;
    #1;
    chk_t("areset_mid_cycle", 1'b0);
    rst_t = 1'b0;
    #1;
    chk_t("areset_released", 1'b0);
    tick();
    tick();
    chk_t("areset_stays_zero", 1'b0);
    st_t = 1'b1; d_t = 1'b1;
    tick();
    st_t = 1'b0; d_t = 1'b0;
    #1;
    chk_t("areset_recapture", 1'b1);
  endtask

  task automatic test_reset_st_high();
    rst_t = 1'b1; st_t = 1'b1; d_t = 1'b1;
    #1;
    chk_t("rst_st_bypass", 1'b1);
    tick();
    chk_t("rst_st_bypass_clk", 1'b1);
    st_t = 1'b0;
    #1;
    chk_t("rst_st_drop", 1'b0);
    rst_t = 1'b0;
    tick();
    chk_t("rst_st_no_capture", 1'b0);
  endtask

  task automatic test_registered();
    st_r = 1'b1; d_r = 8'hA5;
    #1;
    chk_r("reg_before_edge", 8'h00);
    tick();
    chk_r("reg_after_edge", 8'hA5);
    st_r = 1'b0; d_r = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_r($sformatf("reg_hold_%0d", i), 8'hA5);
    end
    st_r = 1'b1;
    #1;
    chk_r("reg_no_bypass", 8'hA5);
    tick();
    chk_r("reg_recapture", 8'h3C);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'h5A; vals[3] = 8'hC3;
    st_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_r = vals[i];
      tick();
      chk_r($sformatf("b2b_%0d", i), vals[i]);
    end
    st_r = 1'b0;
    #1 rst_r = 1'b1;
    #1;
    chk_r("reg_async_reset", 8'h00);
    rst_r = 1'b0;
    tick();
    chk_r("reg_reset_hold", 8'h00);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_transparent_follow();
    test_hold_capture();
    test_hold_zero();
    test_async_reset();
    test_reset_st_high();
    test_registered();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
